tri_fetch: RTL and testbench



---
 rtl/tri_fetch_if.sv | 28 ++
 rtl/tri_fetch.sv | 166 ++++++++++++++++
 tb/tb_tri_fetch.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_fetch_if.sv
// rtl/tri_fetch_if.sv - triangle fetch bus: frame control, vertex BRAM read port, triangle valid/ready output
interface tri_fetch_if #(
  parameter int NUM_TRI = 2048,
  parameter int P_WIDTH = 16,
  parameter int TRI_W   = $clog2(NUM_TRI),
  parameter int ADDR_W  = $clog2(3 * NUM_TRI)
);
  logic                                start_in;
  logic [TRI_W:0]                      num_tri_in;
  logic [ADDR_W-1:0]                   addr_out;
  logic signed [2:0][P_WIDTH-1:0]      data_in;
  logic                                valid_out;
  logic                                ready_in;
  logic [TRI_W-1:0]                    tri_id_out;
  logic signed [2:0][2:0][P_WIDTH-1:0] P_out;
  logic                                busy_out;
  logic                                frame_done_out;

  modport master (
    input  start_in, num_tri_in, data_in, ready_in,
    output addr_out, valid_out, tri_id_out, P_out, busy_out, frame_done_out
  );

  modport slave (
    output start_in, num_tri_in, data_in, ready_in,
    input  addr_out, valid_out, tri_id_out, P_out, busy_out, frame_done_out
  );
endinterface

// File: rtl/tri_fetch.sv
// rtl/tri_fetch.sv - walks triangles 0..n-1, reads three vertex words each from BRAM, presents them on valid/ready
module tri_fetch #(
  parameter int NUM_TRI      = 2048,
  parameter int P_WIDTH      = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  tri_fetch_if.master bus
);
  localparam int TRI_W  = $clog2(NUM_TRI);
  localparam int ADDR_W = $clog2(3 * NUM_TRI);
  localparam logic [TRI_W:0] NUM_TRI_C = (TRI_W + 1)'(NUM_TRI);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t                              state_q, state_d;
  logic [TRI_W:0]                      n_q, n_d;
  logic [TRI_W-1:0]                    tri_id_q, tri_id_d;
  logic [ADDR_W-1:0]                   base_q, base_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [1:0]                          fslot_q, fslot_d;
  logic [BRAM_LATENCY-1:0]             vld_sr_q, vld_sr_d;
  logic [BRAM_LATENCY-1:0][1:0]        slot_sr_q, slot_sr_d;
  logic signed [2:0][2:0][P_WIDTH-1:0] p_q, p_d;
  logic                                valid_q, valid_d;
  logic                                done_q, done_d;

  logic           issue;
  logic [1:0]     issue_slot;
  logic [TRI_W:0] n_clamp;
  logic           ret_vld;
  logic [1:0]     ret_slot;
  logic           last_ret;
  logic           last_tri;

  // Stage 0 of the return pipe is aligned with the address currently on addr_out.
  assign ret_vld  = vld_sr_q[BRAM_LATENCY-1];
  assign ret_slot = slot_sr_q[BRAM_LATENCY-1];
  assign last_ret = ret_vld && (ret_slot == 2'd2);
  assign last_tri = ({1'b0, tri_id_q} == (n_q - (TRI_W + 1)'(1)));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    tri_id_d   = tri_id_q;
    base_d     = base_q;
    addr_d     = addr_q;
    fslot_d    = fslot_q;
    p_d        = p_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_slot = 2'd0;
    n_clamp    = (bus.num_tri_in > NUM_TRI_C) ? NUM_TRI_C : bus.num_tri_in;

    if (ret_vld) begin
      p_d[ret_slot] = bus.data_in;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          n_d      = n_clamp;
          tri_id_d = '0;
          base_d   = '0;
          if (n_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = '0;
            fslot_d = 2'd0;
            issue   = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (fslot_q != 2'd2) begin
          addr_d     = addr_q + ADDR_W'(1);
          fslot_d    = fslot_q + 2'd1;
          issue      = 1'b1;
          issue_slot = fslot_q + 2'd1;
        end else if (last_ret) begin
          // Single-cycle BRAM: slot 2 returns while its address is still on the bus.
          state_d = S_HOLD;
          valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (last_ret) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.ready_in) begin
          valid_d = 1'b0;
          if (last_tri) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tri_id_d = tri_id_q + TRI_W'(1);
            base_d   = base_q + ADDR_W'(3);
            addr_d   = base_q + ADDR_W'(3);
            fslot_d  = 2'd0;
            issue    = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    vld_sr_d     = vld_sr_q;
    slot_sr_d    = slot_sr_q;
    vld_sr_d[0]  = issue;
    slot_sr_d[0] = issue_slot;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      slot_sr_d[i] = slot_sr_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      n_q       <= '0;
      tri_id_q  <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      fslot_q   <= '0;
      vld_sr_q  <= '0;
      slot_sr_q <= '0;
      p_q       <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      n_q       <= n_d;
      tri_id_q  <= tri_id_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      fslot_q   <= fslot_d;
      vld_sr_q  <= vld_sr_d;
      slot_sr_q <= slot_sr_d;
      p_q       <= p_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.addr_out       = addr_q;
  assign bus.valid_out      = valid_q;
  assign bus.tri_id_out     = tri_id_q;
  assign bus.P_out          = p_q;
  assign bus.busy_out       = (state_q != S_IDLE);
  assign bus.frame_done_out = done_q;
endmodule

// File: tb/tb_tri_fetch.sv
// tb/tb_tri_fetch.sv - scoreboard bench for tri_fetch with BRAM models at latencies 2, 1 and 4
module tb_tri_fetch;
  localparam int NUM_TRI = 2048;
  localparam int P_WIDTH = 16;
  localparam int TRI_W   = $clog2(NUM_TRI);
  localparam int ADDR_W  = $clog2(3 * NUM_TRI);

  typedef struct {
    int           id;
    logic [143:0] p;
    bit           last;
  } tri_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ev_cyc = 0;
  int   exp_done_cyc = -1;
  int   xfers = 0;
  int   dones = 0;
  int   rmode = 0;
  tri_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tri_fetch_if #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH)) bm ();
  tri_fetch_if #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH)) b1 ();
  tri_fetch_if #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH)) b4 ();

  tri_fetch #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH), .BRAM_LATENCY(2)) u_main (.clk_in(clk), .rst_in(rst), .bus(bm));
  tri_fetch #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH), .BRAM_LATENCY(1)) u_l1 (.clk_in(clk), .rst_in(rst), .bus(b1));
  tri_fetch #(.NUM_TRI(NUM_TRI), .P_WIDTH(P_WIDTH), .BRAM_LATENCY(4)) u_l4 (.clk_in(clk), .rst_in(rst), .bus(b4));

  function automatic logic [3*P_WIDTH-1:0] word(input int a);
    logic [P_WIDTH-1:0] x, y, z;
    x = P_WIDTH'(a);
    y = P_WIDTH'(a + 1000);
    z = P_WIDTH'(a + 2000);
    return {x, y, z};
  endfunction

  function automatic logic [143:0] tri_exp(input int i);
    return {word(3 * i + 2), word(3 * i + 1), word(3 * i)};
  endfunction

  // BRAM models: data for the address shown in cycle c is on data_in during cycle c+L-1.
  logic [ADDR_W-1:0] am_q, a4_0, a4_1, a4_2;
  always @(posedge clk) begin
    am_q <= bm.addr_out;
    a4_0 <= b4.addr_out;
    a4_1 <= a4_0;
    a4_2 <= a4_1;
  end
  assign bm.data_in = word(int'(am_q));
  assign b1.data_in = word(int'(b1.addr_out));
  assign b4.data_in = word(int'(a4_2));

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int num);
    int n;
    n = (num > NUM_TRI) ? NUM_TRI : num;
    for (int i = 0; i < n; i++) exp_q.push_back('{id: i, p: tri_exp(i), last: (i == n - 1)});
    ev_cyc = cyc;
    if (n == 0) exp_done_cyc = cyc + 1;
    bm.num_tri_in = (TRI_W + 1)'(num);
    bm.start_in   = 1'b1;
    tick(1);
    bm.start_in   = 1'b0;
    bm.num_tri_in = (TRI_W + 1)'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || exp_done_cyc >= 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: %0d triangles still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic monitor();
    logic pv = 1'b0, pr = 1'b0;
    logic [143:0] pp = '0;
    logic [TRI_W-1:0] pid = '0;
    logic [ADDR_W-1:0] pa = '0;
    tri_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_valid", bm.valid_out, 1'b1);
        chk("hold_p", $unsigned(bm.P_out), pp);
        chk("hold_id", bm.tri_id_out, pid);
        chk("hold_addr", bm.addr_out, pa);
      end
      if (bm.valid_out && !pv) chk("valid_rise_cycle", cyc, ev_cyc + 5);
      if (bm.valid_out && bm.ready_in) begin
        chk("xfer_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tri_id", bm.tri_id_out, e.id);
          chk("tri_p", $unsigned(bm.P_out), e.p);
          if (e.last) exp_done_cyc = cyc + 1;
        end
        ev_cyc = cyc;
        xfers++;
      end
      if (bm.frame_done_out) begin
        chk("done_cycle", cyc, exp_done_cyc);
        chk("done_busy", bm.busy_out, 1'b0);
        exp_done_cyc = -1;
        dones++;
      end else if (exp_done_cyc == cyc) begin
        chk("done_missing", bm.frame_done_out, 1'b1);
        exp_done_cyc = -1;
      end
      pv  = bm.valid_out;
      pr  = bm.ready_in;
      pp  = bm.P_out;
      pid = bm.tri_id_out;
      pa  = bm.addr_out;
    end
  endtask

  task automatic ready_driver();
    int hcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bm.ready_in = 1'b1;
        1: bm.ready_in = ($urandom_range(0, 3) != 0);
        default: begin
          if (bm.valid_out && hcnt < 10) begin
            bm.ready_in = 1'b0;
            hcnt++;
          end else begin
            bm.ready_in = bm.valid_out;
            if (!bm.valid_out) hcnt = 0;
          end
        end
      endcase
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, bm.valid_out, 1'b0);
    chk({tag, "_busy"}, bm.busy_out, 1'b0);
    chk({tag, "_done"}, bm.frame_done_out, 1'b0);
    chk({tag, "_addr"}, bm.addr_out, '0);
    chk({tag, "_id"}, bm.tri_id_out, '0);
    chk({tag, "_p"}, $unsigned(bm.P_out), '0);
  endtask

  initial begin
    int n, s, r1, r4, k, d0;
    logic [ADDR_W-1:0] a0;
    rst = 1'b1;
    bm.start_in = 1'b0; bm.num_tri_in = '0; bm.ready_in = 1'b1;
    b1.start_in = 1'b0; b1.num_tri_in = (TRI_W + 1)'(1); b1.ready_in = 1'b1;
    b4.start_in = 1'b0; b4.num_tri_in = (TRI_W + 1)'(1); b4.ready_in = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    tick(3);
    chk_reset("reset");
    rst = 1'b0;

    // Basic frame: start in cycle 10, valid at 15/20/25, done at 26.
    while (cyc < 10) tick(1);
    xfers = 0;
    start_frame(3);
    wait_done(100);
    chk("basic_xfers", xfers, 3);

    // Backpressure: ready held low for 10 valid cycles.
    rmode = 2; xfers = 0;
    start_frame(2);
    wait_done(200);
    chk("bp_xfers", xfers, 2);

    // Random frames with random ready and an ignored start while busy.
    rmode = 1;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 12);
      xfers = 0;
      start_frame(n);
      tick(3);
      bm.num_tri_in = (TRI_W + 1)'(n + 3);
      bm.start_in = 1'b1;
      tick(1);
      bm.start_in = 1'b0;
      wait_done(n * 40 + 50);
      chk("rand_xfers", xfers, n);
    end

    // Zero-length frame.
    rmode = 0; tick(2);
    a0 = bm.addr_out; d0 = dones;
    start_frame(0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_busy", bm.busy_out, 1'b0);
      chk("zero_addr", bm.addr_out, a0);
      tick(1);
    end
    wait_done(10);
    chk("zero_dones", dones - d0, 1);

    // Start in the same cycle as frame_done.
    xfers = 0;
    start_frame(1);
    k = 0;
    while (exp_done_cyc != cyc && k < 50) begin tick(1); k++; end
    chk("b2b_done_seen", exp_done_cyc, cyc);
    start_frame(2);
    wait_done(100);
    chk("b2b_xfers", xfers, 3);

    // Reset one cycle after the slot-1 address.
    start_frame(3);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_reset("midrst");
    exp_q.delete();
    exp_done_cyc = -1;
    rst = 1'b0;
    tick(4);
    chk("midrst_late_p", $unsigned(bm.P_out), '0);
    chk("midrst_late_valid", bm.valid_out, 1'b0);
    xfers = 0;
    start_frame(1);
    wait_done(50);
    chk("midrst_fresh_xfers", xfers, 1);

    // Clamp: NUM_TRI+5 requested.
    xfers = 0;
    start_frame(NUM_TRI + 5);
    wait_done(NUM_TRI * 6 + 100);
    chk("clamp_xfers", xfers, NUM_TRI);
    chk("clamp_last_id", bm.tri_id_out, NUM_TRI - 1);
    chk("clamp_last_addr", bm.addr_out, 3 * NUM_TRI - 1);

    // Latency sweep on the L=1 and L=4 instances.
    s = cyc; r1 = -1; r4 = -1;
    b1.start_in = 1'b1; b4.start_in = 1'b1;
    tick(1);
    b1.start_in = 1'b0; b4.start_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b1.valid_out && r1 < 0) begin
        r1 = cyc;
        chk("l1_p", $unsigned(b1.P_out), tri_exp(0));
      end
      if (b4.valid_out && r4 < 0) begin
        r4 = cyc;
        chk("l4_p", $unsigned(b4.P_out), tri_exp(0));
      end
      tick(1);
    end
    chk("l1_valid_cycle", r1, s + 4);
    chk("l4_valid_cycle", r4, s + 7);
    chk("l1_idle_after", b1.busy_out, 1'b0);
    chk("l4_idle_after", b4.busy_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
